// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, funct codes, ALU operations, multicycle states
// and the ALU-control decode.
package mips_pkg;
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXEC, S_RCOMP, S_BRANCH, S_JUMP
  } state_e;

  // Unlisted funct codes fall back to add rather than trapping.
  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      2'b01: op = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/mc_datapath_if.sv
// Control-unit and memory-port bundle seen by the multicycle datapath.
interface mc_datapath_if;
  logic [3:0]  next;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite;
  logic        MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic [5:0]  Op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [31:0] pc_dbg;

  modport master (
    output next, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, mem_rdata,
    input  state, Op, mem_addr, mem_wdata, mem_read, mem_write, pc_dbg
  );

  modport slave (
    input  next, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, mem_rdata,
    output state, Op, mem_addr, mem_wdata, mem_read, mem_write, pc_dbg
  );
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, synchronous clear.
module mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old contents.
  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: state register, PC/IR/MDR/A/B/ALUOut, register file,
// inline ALU and ALU control, single shared memory port.
module mc_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  mc_datapath_if.slave bus
);
  state_e      st;
  logic [31:0] pc, ir, mdr, a, b, aluout;
  logic [31:0] rf_a, rf_b, se, srca, srcb, alu_y, pc_next;
  alu_op_e     alu_ctl;
  logic        zero, pc_en;

  // Encodings 10-15 are unused; collapse them onto fetch.
  always_ff @(posedge clk) begin
    if (rst) st <= S_FETCH;
    else     st <= (bus.next > 4'd9) ? S_FETCH : state_e'(bus.next);
  end

  mc_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .we  (bus.RegWrite),
    .wa  (bus.RegDst ? ir[15:11] : ir[20:16]),
    .wd  (bus.MemtoReg ? mdr : aluout),
    .rd1 (rf_a),
    .rd2 (rf_b)
  );

  assign se      = {{16{ir[15]}}, ir[15:0]};
  assign srca    = bus.ALUSrcA ? a : pc;
  assign alu_ctl = alu_decode(bus.ALUOp, ir[5:0]);

  always_comb begin
    srcb = b;
    case (bus.ALUSrcB)
      2'b00:   srcb = b;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = se;
      default: srcb = {se[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_y = srca + srcb;
    case (alu_ctl)
      ALU_SUB: alu_y = srca - srcb;
      ALU_AND: alu_y = srca & srcb;
      ALU_OR:  alu_y = srca | srcb;
      ALU_SLT: alu_y = {31'b0, $signed(srca) < $signed(srcb)};
      default: alu_y = srca + srcb;
    endcase
  end

  assign zero  = (alu_y == 32'd0);
  assign pc_en = bus.PCWrite | (bus.PCWriteCond & zero);

  always_comb begin
    pc_next = alu_y;
    case (bus.PCSource)
      2'b01:   pc_next = aluout;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (bus.IRWrite) ir <= bus.mem_rdata;
      if (pc_en)       pc <= pc_next;
      mdr    <= bus.mem_rdata;
      a      <= rf_a;
      b      <= rf_b;
      aluout <= alu_y;
    end
  end

  assign bus.state     = st;
  assign bus.Op        = ir[31:26];
  assign bus.mem_addr  = bus.IorD ? aluout : pc;
  assign bus.mem_wdata = b;
  assign bus.mem_read  = bus.MemRead;
  assign bus.mem_write = bus.MemWrite;
  assign bus.pc_dbg    = pc;
endmodule

// File: tb/tb_mc_datapath.sv
// Bench: acts as control unit and memory; an ISA-level model predicts every memory
// access, which a separate monitor pops and compares as the DUT presents it.
module tb_mc_datapath;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_datapath_if bus ();
  mc_datapath #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem  [0:1023];
  logic [31:0] mmem [0:1023];
  logic [31:0] mreg [0:31];
  logic [31:0] mpc;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} ev_t;
  ev_t exq[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (bus.mem_read || bus.mem_write)) begin
      if (exq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_access: got addr %h wr %0d expected none", bus.mem_addr, bus.mem_write);
      end else begin
        e = exq.pop_front();
        chk("access_dir", {31'b0, bus.mem_write}, {31'b0, e.wr});
        chk("mem_addr", bus.mem_addr, e.addr);
        if (e.wr) chk("mem_wdata", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic drive(input state_e s, input logic [3:0] nx);
    bus.next = nx;
    {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite} = '0;
    {bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst} = '0;
    bus.PCSource = 2'b00; bus.ALUOp = 2'b00; bus.ALUSrcB = 2'b00;
    case (s)
      S_FETCH:  begin bus.MemRead = 1; bus.IRWrite = 1; bus.ALUSrcB = 2'b01; bus.PCWrite = 1; end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR: begin bus.ALUSrcA = 1; bus.ALUSrcB = 2'b10; end
      S_MEMRD:  begin bus.MemRead = 1; bus.IorD = 1; end
      S_MEMWB:  begin bus.RegWrite = 1; bus.MemtoReg = 1; end
      S_MEMWR:  begin bus.MemWrite = 1; bus.IorD = 1; end
      S_EXEC:   begin bus.ALUSrcA = 1; bus.ALUOp = 2'b10; end
      S_RCOMP:  begin bus.RegWrite = 1; bus.RegDst = 1; end
      S_BRANCH: begin bus.ALUSrcA = 1; bus.ALUOp = 2'b01; bus.PCWriteCond = 1; bus.PCSource = 2'b01; end
      S_JUMP:   begin bus.PCWrite = 1; bus.PCSource = 2'b10; end
      default: ;
    endcase
  endtask

  // One control cycle, entered and left 1 time unit after a rising edge.
  task automatic cyc(input state_e s, input logic [3:0] nx, input bit do_rst);
    drive(s, nx);
    rst = do_rst;
    @(negedge clk);
    chk("state", {28'b0, bus.state}, {28'b0, s});
    if (bus.mem_write) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
    @(posedge clk); #1;
  endtask

  task automatic setmem(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[11:2]] = val;
    mmem[addr[11:2]] = val;
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {OP_R, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] jtype(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  // Place the instruction at the model PC, execute it architecturally, queue its
  // memory accesses, then step the control sequence (optionally resetting at rst_at).
  task automatic issue(input logic [31:0] ins, input int rst_at);
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, pc4, va, vb, addr, res;
    state_e      seq[$];
    logic [3:0]  nx;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    imm = {{16{ins[15]}}, ins[15:0]};
    setmem(mpc, ins);
    exq.push_back('{0, mpc, 32'h0});
    pc4 = mpc + 32'd4;
    va = mreg[rs]; vb = mreg[rt];
    mpc = pc4;
    case (ins[31:26])
      OP_LW: begin
        addr = va + imm;
        exq.push_back('{0, addr, 32'h0});
        if (rt != 0) mreg[rt] = mmem[addr[11:2]];
        seq = {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      end
      OP_SW: begin
        addr = va + imm;
        exq.push_back('{1, addr, vb});
        mmem[addr[11:2]] = vb;
        seq = {S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
      end
      OP_BEQ: begin
        if (va == vb) mpc = pc4 + imm * 4;
        seq = {S_FETCH, S_DECODE, S_BRANCH};
      end
      OP_J: begin
        mpc = {pc4[31:28], ins[25:0], 2'b00};
        seq = {S_FETCH, S_DECODE, S_JUMP};
      end
      default: begin
        case (ins[5:0])
          FN_SUB:  res = va - vb;
          FN_AND:  res = va & vb;
          FN_OR:   res = va | vb;
          FN_SLT:  res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: res = va + vb;
        endcase
        if (rd != 0) mreg[rd] = res;
        seq = {S_FETCH, S_DECODE, S_EXEC, S_RCOMP};
      end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      nx = (i == seq.size() - 1) ? 4'd0 : 4'(seq[i+1]);
      cyc(seq[i], nx, i == rst_at);
      if (i == rst_at) begin
        rst = 1'b0;
        mpc = 32'h0;
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [6];
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'h07};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      mmem[i] = mem[i];
    end
    for (int r = 0; r < 32; r++) mreg[r] = '0;
    mpc = 32'h0;
    rst = 1'b1;
    drive(S_FETCH, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {28'b0, bus.state}, 32'h0);
    chk("rst_pc", bus.pc_dbg, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_op", {26'b0, bus.Op}, 32'h0);

    rst = 1'b0;
    drive(S_MEMADR, 4'd3);
    bus.MemRead = 1'b0; bus.IRWrite = 1'b0; bus.PCWrite = 1'b0;
    bus.ALUSrcA = 1'b0; bus.ALUSrcB = 2'b00;
    @(posedge clk); #1;
    chk("state_follow", {28'b0, bus.state}, 32'd3);
    bus.next = 4'd9;
    @(posedge clk); #1;
    chk("state_9", {28'b0, bus.state}, 32'd9);
    bus.next = 4'hC;
    @(posedge clk); #1;
    chk("state_C_to_0", {28'b0, bus.state}, 32'd0);
    chk("pc_idle", bus.pc_dbg, 32'h0);

    // lw / sw
    setmem(32'h600, 32'h100);      issue(itype(OP_LW, 0, 1, 16'h0600), -1);
    setmem(32'h104, 32'hDEADBEEF); issue(itype(OP_LW, 1, 2, 16'h0004), -1);
    issue(itype(OP_SW, 0, 2, 16'h0700), -1);
    setmem(32'h604, 32'h200);      issue(itype(OP_LW, 0, 1, 16'h0604), -1);
    setmem(32'h608, 32'h12345678); issue(itype(OP_LW, 0, 3, 16'h0608), -1);
    issue(itype(OP_SW, 1, 3, 16'hFFF8), -1);
    // R-type
    setmem(32'h60C, 32'd5); issue(itype(OP_LW, 0, 4, 16'h060C), -1);
    setmem(32'h610, 32'd7); issue(itype(OP_LW, 0, 5, 16'h0610), -1);
    issue(rtype(FN_SUB, 6, 4, 5), -1);
    issue(rtype(FN_SLT, 7, 4, 5), -1);
    issue(rtype(FN_ADD, 0, 4, 5), -1);
    issue(itype(OP_SW, 0, 6, 16'h0704), -1);
    issue(itype(OP_SW, 0, 7, 16'h0708), -1);
    issue(itype(OP_SW, 0, 0, 16'h070C), -1);
    // beq from 0x40, taken then not taken
    issue(jtype(26'h10), -1);
    issue(itype(OP_BEQ, 4, 4, 16'd3), -1);
    issue(jtype(26'h10), -1);
    issue(itype(OP_BEQ, 4, 5, 16'd3), -1);
    // j, then reset while in the jump state
    issue(jtype(26'h100), -1);
    issue(jtype(26'h200), 2);
    chk("rst_in_j_pc", bus.pc_dbg, 32'h0);
    chk("rst_in_j_state", {28'b0, bus.state}, 32'h0);
    issue(itype(OP_SW, 0, 2, 16'h0700), -1);

    for (int n = 0; n < 200; n++) begin
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); imm = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    issue(itype(OP_LW, rs, rt, imm), -1);
        2, 3:    issue(itype(OP_SW, rs, rt, imm), -1);
        4:       issue(itype(OP_BEQ, rs, ($urandom_range(0, 1) == 0) ? rs : rt, imm), -1);
        5:       issue(jtype(26'($urandom)), -1);
        default: issue(rtype(fns[$urandom_range(0, 5)], rd, rs, rt), -1);
      endcase
    end
    for (int r = 1; r < 32; r++) issue(itype(OP_SW, 0, 5'(r), 16'(32'h800 + 4 * r)), -1);

    drive(S_FETCH, 4'd0);
    bus.MemRead = 1'b0; bus.IRWrite = 1'b0; bus.PCWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS datapath and state register: holds PC, IR, MDR, A, B, ALUOut, the 32×32 register file, ALU and ALU-control decode. Sits directly downstream of the multicycle control unit. It consumes that unit's control strobes and `next` state, and feeds back the registered `state` and the instruction `Op` field. It drives a single shared instruction/data memory port.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- next  in  4  next state from control unit
- PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  in  1 each  control strobes
- PCSource, ALUOp, ALUSrcB  in  2 each  control selects
- state  out  4  current FSM state (registered)
- Op  out  6  IR[31:26]
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  store data (= B)
- mem_rdata  in  32  memory read data, combinational (valid same cycle as mem_addr)
- mem_read, mem_write  out  1  pass-through of MemRead / MemWrite
- pc_dbg  out  32  current PC

## Operation
- State register: `state` ← `next` every edge. Values 10–15 are loaded as 0.
- mem_addr: IorD=0 → PC; IorD=1 → ALUOut.
- IR ← mem_rdata when IRWrite. MDR ← mem_rdata every cycle.
- A ← rf[IR[25:21]], B ← rf[IR[20:16]] every cycle.
- ALUOut ← ALU result every cycle.
- ALU input A mux: ALUSrcA=0 → PC; 1 → A.
- ALU input B mux (SE = sign-extended IR[15:0]):
  - 00 → B
  - 01 → 32'd4
  - 10 → SE
  - 11 → SE<<2
- ALU control:
  - ALUOp=00 → add; 01 → sub; 11 → add.
  - ALUOp=10 decodes IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Any other funct → add.
- Zero = (ALU result == 0).
- PC write enable = PCWrite | (PCWriteCond & Zero).
- PC source:
  - PCSource 00 → ALU result
  - 01 → ALUOut
  - 10 → {PC[31:28], IR[25:0], 2'b00}
  - 11 → ALU result
- Register file write on RegWrite:
  - Address: RegDst=1 → IR[15:11]; 0 → IR[20:16].
  - Data: MemtoReg=1 → MDR; 0 → ALUOut.
  - Writes to r0 ignored; r0 always reads 0.
- Arithmetic is 32-bit wrap-around. Overflow is ignored, no exceptions.

## Timing
- Reset values:
  - state=0, PC=RESET_PC, all other datapath registers=0, all 32 registers=0.
  - Outputs during/after reset: state=0, Op=0, pc_dbg=RESET_PC, mem_addr=RESET_PC (IorD low), mem_wdata=0.
- Reset asserted mid-instruction: next edge restores all reset values; in-flight writes at that edge are suppressed.
- Register file reads are asynchronous; writes take effect at the clock edge.
- Same-cycle read of the register being written returns the old value; no bypass.
- Memory write is owned by memory on the edge where mem_write=1.
- Instruction cycle counts (state 0 is fetch):
  - lw: 5 cycles
  - sw, R-type: 4 cycles
  - beq, j: 3 cycles
- Fetch (state 0): IR and PC+4 both commit at the end of the cycle.
- Decode (state 1): ALUOut ← PC+4 + (SE<<2), the branch target.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (R=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, J=6'h02)
  - funct constants
  - ALU-operation enum
  - state encodings 0–9
- Sub-module `mc_regfile`: 32×32, two async read ports, one sync write port, r0 hardwired, synchronous clear on rst.
- ALU and ALU control stay inline.

## Test plan
- Reset: hold rst 2 cycles → state=0, pc_dbg=0, mem_addr=0. Then state follows a driven `next`; next=4'hC loads 0.
- lw: r1=0x100, mem[0x104]=0xDEADBEEF, IR=lw r2,4(r1), states 0→1→2→3→4 → mem_addr=0x104 in state 3; r2=0xDEADBEEF; PC=4.
- sw: r1=0x200, r3=0x12345678, sw r3,-8(r1) → in state 5 mem_addr=0x1F8, mem_wdata=0x12345678, mem_write=1.
- R-type: r4=5, r5=7, states 0,1,6,7:
  - sub r6,r4,r5 → r6=0xFFFFFFFE
  - slt r7,r4,r5 → r7=1
  - add r0,r4,r5 → r0 stays 0
- beq at PC=0x40, offset 3:
  - equal operands → PC=0x50
  - unequal operands → PC=0x44
- j: at PC=0x8000_0010, target field 0x100 → PC=0x8000_0400. Assert rst in state 9 → PC=RESET_PC.
